pipe_reg_chain: RTL

Parametrised successor to the team's 8-bit reset-able D register. It is a chain of DEPTH WIDTH-bit pipeline registers with a valid/ready handshake on each end. Each stage holds a valid bit and supports bubble collapse, backpressure and synchronous flush. It sits between ALU datapath stages, for example between the operand latch and the ALU, or between the ALU and the result writeback.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_stage.sv | 38 +++
 rtl/pipe_reg_chain.sv | 93 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline register chains placed between ALU datapath stages.
package pipe_pkg;

  localparam int unsigned PIPE_RESET_VAL = 0;

  // Bits needed to count 0..depth occupied stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid+data pipeline register; data only captures when a valid item arrives.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = WIDTH'(PIPE_RESET_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      data_reg  <= RESET_VAL;
    end else if (flush) begin
      valid_reg <= 1'b0;
      data_reg  <= RESET_VAL;
    end else if (load) begin
      valid_reg <= src_valid;
      // A bubble passing through clears valid but leaves the old data in place.
      if (src_valid) data_reg <= src_data;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register chain with bubble collapse, backpressure and flush.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL),
  localparam int unsigned     OW        = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OW-1:0]    occupancy
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_ready;
  logic [WIDTH-1:0] stage_data [DEPTH];

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (gi == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = stage_valid[gi-1];
      assign src_data  = stage_data[gi-1];
    end

    // A stage can take new data if downstream pops or any stage at or beyond it is empty.
    assign stage_ready[gi] = out_ready | ~(&stage_valid[DEPTH-1:gi]);

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .load      (stage_ready[gi]),
      .src_valid (src_valid),
      .src_data  (src_data),
      .valid     (stage_valid[gi]),
      .data      (stage_data[gi])
    );
  end

  assign in_ready  = stage_ready[0] & ~flush;
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

  logic          in_accept;
  logic          out_accept;
  logic [OW-1:0] occ_reg;
  logic [OW-1:0] occ_next;

  assign in_accept  = in_valid & in_ready;
  assign out_accept = out_valid & out_ready;

  always_comb begin
    occ_next = occ_reg;
    if (flush) begin
      occ_next = '0;
    end else begin
      case ({in_accept, out_accept})
        2'b10:   occ_next = occ_reg + OW'(1);
        2'b01:   occ_next = occ_reg - OW'(1);
        default: occ_next = occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ_reg <= '0;
    else        occ_reg <= occ_next;
  end

  assign occupancy = occ_reg;

endmodule
